// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, CDB capture, in-order commit, mispredict rollback.
// Optional ROB_CDB_BYPASS_EN: operand queries also see the CDB broadcast in the same cycle.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned TAG_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_assign_ena,
  input  logic [31:0]       in_inst,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_pc,
  input  logic              in_predicted_taken,
  output logic [TAG_W-1:0]  out_tobe_tag,
  output logic              out_full,
  input  logic [TAG_W-1:0]  in_query_tag1,
  input  logic [TAG_W-1:0]  in_query_tag2,
  output logic              out_query_tag1_ready,
  output logic              out_query_tag2_ready,
  output logic [31:0]       out_query_value1,
  output logic [31:0]       out_query_value2,
  input  logic              in_cdb_ena,
  input  logic [TAG_W-1:0]  in_cdb_tag,
  input  logic [31:0]       in_cdb_value,
  input  logic              in_cdb_taken,
  input  logic [31:0]       in_cdb_target,
  output logic              out_commit_reg_ena,
  output logic [4:0]        out_commit_rd,
  output logic [31:0]       out_commit_value,
  output logic [TAG_W-1:0]  out_commit_tag,
  output logic              out_commit_store_ena,
  output logic [TAG_W-1:0]  out_commit_store_tag,
  output logic              out_rollback,
  output logic [31:0]       out_correct_pc
);

  localparam logic [TAG_W-1:0] ZERO_ROB  = '0;
  localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(ROB_SIZE - 1);

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    KIND_OTHER,
    KIND_STORE,
    KIND_BRANCH,
    KIND_JALR
  } op_kind_e;

  logic              valid_q  [ROB_SIZE];
  logic              ready_q  [ROB_SIZE];
  logic [6:0]        op_q     [ROB_SIZE];
  logic [4:0]        rd_q     [ROB_SIZE];
  logic [31:0]       pc_q     [ROB_SIZE];
  logic              pred_q   [ROB_SIZE];
  logic [31:0]       value_q  [ROB_SIZE];
  logic              taken_q  [ROB_SIZE];
  logic [31:0]       target_q [ROB_SIZE];

  logic [TAG_W-1:0]  head_q, tail_q, count_q;

  op_kind_e          head_kind;
  logic              commit_fire, rollback_now, alloc_fire, cdb_fire;
  logic [31:0]       redirect_pc;
  logic              bypass_hit1, bypass_hit2;

  logic unused_inst;
  assign unused_inst = ^in_inst[31:7];

  // Slot 0 is the "no tag" value, so pointers skip it on wrap.
  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] t);
    return (t == LAST_TAG) ? FIRST_TAG : t + FIRST_TAG;
  endfunction

  assign out_tobe_tag = tail_q;
  assign out_full     = (count_q == LAST_TAG);

  always_comb begin
    head_kind = KIND_OTHER;
    case (op_q[head_q])
      OPC_STORE:  head_kind = KIND_STORE;
      OPC_BRANCH: head_kind = KIND_BRANCH;
      OPC_JALR:   head_kind = KIND_JALR;
      default:    head_kind = KIND_OTHER;
    endcase
    commit_fire  = valid_q[head_q] && ready_q[head_q];
    rollback_now = commit_fire &&
                   ((head_kind == KIND_JALR) ||
                    ((head_kind == KIND_BRANCH) && (taken_q[head_q] != pred_q[head_q])));
    if (head_kind == KIND_JALR || taken_q[head_q])
      redirect_pc = target_q[head_q];
    else
      redirect_pc = pc_q[head_q] + 32'd4;
    // A flush this edge discards both the new allocation and the CDB write.
    alloc_fire = in_assign_ena && !out_full && !rollback_now;
    cdb_fire   = in_cdb_ena && (in_cdb_tag != ZERO_ROB) && valid_q[in_cdb_tag] && !rollback_now;
  end

`ifdef ROB_CDB_BYPASS_EN
  assign bypass_hit1 = in_cdb_ena && (in_cdb_tag == in_query_tag1);
  assign bypass_hit2 = in_cdb_ena && (in_cdb_tag == in_query_tag2);
`else
  assign bypass_hit1 = 1'b0;
  assign bypass_hit2 = 1'b0;
`endif

  always_comb begin
    out_query_tag1_ready = 1'b0;
    out_query_value1     = '0;
    out_query_tag2_ready = 1'b0;
    out_query_value2     = '0;
    if (in_query_tag1 != ZERO_ROB && valid_q[in_query_tag1]) begin
      if (bypass_hit1) begin
        out_query_tag1_ready = 1'b1;
        out_query_value1     = in_cdb_value;
      end else if (ready_q[in_query_tag1]) begin
        out_query_tag1_ready = 1'b1;
        out_query_value1     = value_q[in_query_tag1];
      end
    end
    if (in_query_tag2 != ZERO_ROB && valid_q[in_query_tag2]) begin
      if (bypass_hit2) begin
        out_query_tag2_ready = 1'b1;
        out_query_value2     = in_cdb_value;
      end else if (ready_q[in_query_tag2]) begin
        out_query_tag2_ready = 1'b1;
        out_query_value2     = value_q[in_query_tag2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        valid_q[i] <= 1'b0;
        ready_q[i] <= 1'b0;
      end
      head_q               <= FIRST_TAG;
      tail_q               <= FIRST_TAG;
      count_q              <= '0;
      out_commit_reg_ena   <= 1'b0;
      out_commit_rd        <= '0;
      out_commit_value     <= '0;
      out_commit_tag       <= '0;
      out_commit_store_ena <= 1'b0;
      out_commit_store_tag <= '0;
      out_rollback         <= 1'b0;
      out_correct_pc       <= '0;
    end else begin
      out_commit_reg_ena   <= 1'b0;
      out_commit_rd        <= '0;
      out_commit_value     <= '0;
      out_commit_tag       <= '0;
      out_commit_store_ena <= 1'b0;
      out_commit_store_tag <= '0;
      out_rollback         <= 1'b0;
      out_correct_pc       <= '0;

      if (commit_fire) begin
        case (head_kind)
          KIND_STORE: begin
            out_commit_store_ena <= 1'b1;
            out_commit_store_tag <= head_q;
          end
          KIND_BRANCH: ;
          KIND_JALR: begin
            out_commit_reg_ena <= 1'b1;
            out_commit_rd      <= rd_q[head_q];
            out_commit_value   <= value_q[head_q];
            out_commit_tag     <= head_q;
          end
          default: begin
            out_commit_reg_ena <= (rd_q[head_q] != 5'd0);
            out_commit_rd      <= rd_q[head_q];
            out_commit_value   <= value_q[head_q];
            out_commit_tag     <= head_q;
          end
        endcase
      end

      if (rollback_now) begin
        for (int unsigned i = 0; i < ROB_SIZE; i++) valid_q[i] <= 1'b0;
        head_q         <= FIRST_TAG;
        tail_q         <= FIRST_TAG;
        count_q        <= '0;
        out_rollback   <= 1'b1;
        out_correct_pc <= redirect_pc;
      end else begin
        if (commit_fire) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= tag_inc(head_q);
        end
        if (cdb_fire) ready_q[in_cdb_tag] <= 1'b1;
        if (alloc_fire) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          tail_q          <= tag_inc(tail_q);
        end
        case ({alloc_fire, commit_fire})
          2'b10:   count_q <= count_q + FIRST_TAG;
          2'b01:   count_q <= count_q - FIRST_TAG;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Payload fields carry no reset; valid/ready alone decide whether they are observed.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      op_q[tail_q]   <= in_inst[6:0];
      rd_q[tail_q]   <= in_rd;
      pc_q[tail_q]   <= in_pc;
      pred_q[tail_q] <= in_predicted_taken;
    end
    if (cdb_fire) begin
      value_q[in_cdb_tag]  <= in_cdb_value;
      taken_q[in_cdb_tag]  <= in_cdb_taken;
      target_q[in_cdb_tag] <= in_cdb_target;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized run
// against a queue-based model of the buffer's in-order behaviour.
module tb_reorder_buffer;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_assign_ena;
  logic [31:0] in_inst;
  logic [4:0]  in_rd;
  logic [31:0] in_pc;
  logic        in_predicted_taken;
  logic [3:0]  out_tobe_tag;
  logic        out_full;
  logic [3:0]  in_query_tag1, in_query_tag2;
  logic        out_query_tag1_ready, out_query_tag2_ready;
  logic [31:0] out_query_value1, out_query_value2;
  logic        in_cdb_ena;
  logic [3:0]  in_cdb_tag;
  logic [31:0] in_cdb_value;
  logic        in_cdb_taken;
  logic [31:0] in_cdb_target;
  logic        out_commit_reg_ena;
  logic [4:0]  out_commit_rd;
  logic [31:0] out_commit_value;
  logic [3:0]  out_commit_tag;
  logic        out_commit_store_ena;
  logic [3:0]  out_commit_store_tag;
  logic        out_rollback;
  logic [31:0] out_correct_pc;

  int checks = 0;
  int failures = 0;

  reorder_buffer #(.ROB_SIZE(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_assign_ena(in_assign_ena), .in_inst(in_inst), .in_rd(in_rd), .in_pc(in_pc),
    .in_predicted_taken(in_predicted_taken),
    .out_tobe_tag(out_tobe_tag), .out_full(out_full),
    .in_query_tag1(in_query_tag1), .in_query_tag2(in_query_tag2),
    .out_query_tag1_ready(out_query_tag1_ready), .out_query_tag2_ready(out_query_tag2_ready),
    .out_query_value1(out_query_value1), .out_query_value2(out_query_value2),
    .in_cdb_ena(in_cdb_ena), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_cdb_taken(in_cdb_taken), .in_cdb_target(in_cdb_target),
    .out_commit_reg_ena(out_commit_reg_ena), .out_commit_rd(out_commit_rd),
    .out_commit_value(out_commit_value), .out_commit_tag(out_commit_tag),
    .out_commit_store_ena(out_commit_store_ena), .out_commit_store_tag(out_commit_store_tag),
    .out_rollback(out_rollback), .out_correct_pc(out_correct_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_assign_ena = 1'b0; in_inst = '0; in_rd = '0; in_pc = '0; in_predicted_taken = 1'b0;
    in_query_tag1 = '0; in_query_tag2 = '0;
    in_cdb_ena = 1'b0; in_cdb_tag = '0; in_cdb_value = '0; in_cdb_taken = 1'b0; in_cdb_target = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_alloc(input logic [6:0] op, input logic [4:0] rd,
                             input logic [31:0] pc, input logic pred);
    in_assign_ena      = 1'b1;
    in_inst            = {$urandom_range(0, 33554431), op};
    in_rd              = rd;
    in_pc              = pc;
    in_predicted_taken = pred;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_tobe_tag !== 4'd1 || out_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_ptrs: tobe_tag=%0d full=%0b, required tobe_tag=1 full=0", out_tobe_tag, out_full);
    end
    checks++;
    if ({out_commit_reg_ena, out_commit_rd, out_commit_value, out_commit_tag, out_commit_store_ena,
         out_commit_store_tag, out_rollback, out_correct_pc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: reg_ena=%0b store_ena=%0b rollback=%0b pc=%h, required all zero",
               out_commit_reg_ena, out_commit_store_ena, out_rollback, out_correct_pc);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      checks++;
      if (out_tobe_tag !== 4'(i) || out_full !== 1'b0) begin
        failures++;
        $display("FAIL fill_step: tobe_tag=%0d full=%0b, required tobe_tag=%0d full=0", out_tobe_tag, out_full, i);
      end
      drive_alloc(OP_ADD, 5'(i), 32'(i * 4), 1'b0);
      tick();
    end
    checks++;
    if (out_full !== 1'b1 || out_tobe_tag !== 4'd1) begin
      failures++;
      $display("FAIL fill_full: full=%0b tobe_tag=%0d, required full=1 tobe_tag=1", out_full, out_tobe_tag);
    end
    drive_alloc(OP_ADD, 5'd1, 32'h0, 1'b0);
    tick();
    in_assign_ena = 1'b0;
    checks++;
    if (out_full !== 1'b1 || out_tobe_tag !== 4'd1) begin
      failures++;
      $display("FAIL fill_overflow: full=%0b tobe_tag=%0d, required full=1 tobe_tag=1", out_full, out_tobe_tag);
    end
  endtask

  task automatic test_commit_add();
    do_reset();
    drive_alloc(OP_ADD, 5'd5, 32'h40, 1'b0);
    tick();
    in_assign_ena = 1'b0;
    in_cdb_ena = 1'b1; in_cdb_tag = 4'd1; in_cdb_value = 32'h1234;
    tick();
    in_cdb_ena = 1'b0;
    in_query_tag1 = 4'd1;
    #1;
    checks++;
    if (out_query_tag1_ready !== 1'b1 || out_query_value1 !== 32'h1234) begin
      failures++;
      $display("FAIL add_query: ready=%0b value=%h, required ready=1 value=00001234", out_query_tag1_ready, out_query_value1);
    end
    checks++;
    if (out_commit_reg_ena !== 1'b0) begin
      failures++;
      $display("FAIL add_early_commit: reg_ena=%0b, required 0", out_commit_reg_ena);
    end
    tick();
    checks++;
    if (out_commit_reg_ena !== 1'b1 || out_commit_rd !== 5'd5 || out_commit_value !== 32'h1234 || out_commit_tag !== 4'd1) begin
      failures++;
      $display("FAIL add_commit: ena=%0b rd=%0d value=%h tag=%0d, required ena=1 rd=5 value=00001234 tag=1",
               out_commit_reg_ena, out_commit_rd, out_commit_value, out_commit_tag);
    end
    tick();
    checks++;
    if (out_commit_reg_ena !== 1'b0) begin
      failures++;
      $display("FAIL add_pulse: reg_ena=%0b, required 0", out_commit_reg_ena);
    end
  endtask

  task automatic test_branch_rollback();
    do_reset();
    drive_alloc(OP_BEQ, 5'd0, 32'h100, 1'b0);
    tick();
    drive_alloc(OP_ADD, 5'd3, 32'h104, 1'b0);
    tick();
    drive_alloc(OP_ADD, 5'd4, 32'h108, 1'b0);
    tick();
    in_assign_ena = 1'b0;
    in_cdb_ena = 1'b1; in_cdb_tag = 4'd1; in_cdb_value = '0; in_cdb_taken = 1'b1; in_cdb_target = 32'h200;
    tick();
    in_cdb_ena = 1'b0;
    checks++;
    if (out_rollback !== 1'b0) begin
      failures++;
      $display("FAIL br_early: rollback=%0b, required 0", out_rollback);
    end
    tick();
    in_query_tag1 = 4'd2;
    #1;
    checks++;
    if (out_rollback !== 1'b1 || out_correct_pc !== 32'h200) begin
      failures++;
      $display("FAIL br_rollback: rollback=%0b pc=%h, required rollback=1 pc=00000200", out_rollback, out_correct_pc);
    end
    checks++;
    if (out_tobe_tag !== 4'd1 || out_full !== 1'b0 || out_query_tag1_ready !== 1'b0) begin
      failures++;
      $display("FAIL br_flush: tobe_tag=%0d full=%0b q2_ready=%0b, required 1 0 0",
               out_tobe_tag, out_full, out_query_tag1_ready);
    end
    tick();
    checks++;
    if (out_rollback !== 1'b0) begin
      failures++;
      $display("FAIL br_pulse: rollback=%0b, required 0", out_rollback);
    end
  endtask

  task automatic test_wrap();
    int ncommit;
    int ntag;
    do_reset();
    ncommit = 0;
    for (int k = 0; k < 40; k++) begin
      idle_inputs();
      if (k < 20) begin
        ntag = (k % 15) + 1;
        checks++;
        if (out_tobe_tag !== 4'(ntag) || out_tobe_tag === 4'd0) begin
          failures++;
          $display("FAIL wrap_tag: tobe_tag=%0d, required %0d", out_tobe_tag, ntag);
        end
        drive_alloc(OP_ADD, 5'((k % 31) + 1), 32'(k * 4), 1'b0);
      end
      if (k >= 1 && k <= 20) begin
        in_cdb_ena = 1'b1; in_cdb_tag = 4'(((k - 1) % 15) + 1); in_cdb_value = 32'(k - 1);
      end
      tick();
      if (out_commit_reg_ena === 1'b1) begin
        ntag = (ncommit % 15) + 1;
        checks++;
        if (out_commit_tag !== 4'(ntag) || out_commit_value !== 32'(ncommit)) begin
          failures++;
          $display("FAIL wrap_order: tag=%0d value=%0d, required tag=%0d value=%0d",
                   out_commit_tag, out_commit_value, ntag, ncommit);
        end
        ncommit++;
      end
    end
    idle_inputs();
    checks++;
    if (ncommit != 20) begin
      failures++;
      $display("FAIL wrap_count: commits=%0d, required 20", ncommit);
    end
  endtask

  task automatic test_tag0();
    do_reset();
    drive_alloc(OP_ADD, 5'd7, 32'h0, 1'b0);
    tick();
    in_assign_ena = 1'b0;
    in_cdb_ena = 1'b1; in_cdb_tag = 4'd0; in_cdb_value = 32'hDEAD;
    in_query_tag1 = 4'd0;
    #1;
    checks++;
    if (out_query_tag1_ready !== 1'b0 || out_query_value1 !== 32'h0) begin
      failures++;
      $display("FAIL tag0_query: ready=%0b value=%h, required ready=0 value=0", out_query_tag1_ready, out_query_value1);
    end
    tick();
    in_cdb_ena = 1'b0;
    in_query_tag2 = 4'd1;
    tick();
    checks++;
    if (out_query_tag2_ready !== 1'b0 || out_commit_reg_ena !== 1'b0) begin
      failures++;
      $display("FAIL tag0_untouched: tag1_ready=%0b reg_ena=%0b, required 0 0", out_query_tag2_ready, out_commit_reg_ena);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(OP_ADD, 5'(i + 1), 32'(i * 4), 1'b0);
      tick();
    end
    in_assign_ena = 1'b0;
    in_cdb_ena = 1'b1; in_cdb_tag = 4'd3; in_cdb_value = 32'd7;
    in_query_tag1 = 4'd3; in_query_tag2 = 4'd2;
    #1;
    checks++;
`ifdef ROB_CDB_BYPASS_EN
    if (out_query_tag1_ready !== 1'b1 || out_query_value1 !== 32'd7) begin
      failures++;
      $display("FAIL bypass_same_cycle: ready=%0b value=%0d, required ready=1 value=7", out_query_tag1_ready, out_query_value1);
    end
`else
    if (out_query_tag1_ready !== 1'b0 || out_query_value1 !== 32'd0) begin
      failures++;
      $display("FAIL bypass_same_cycle: ready=%0b value=%0d, required ready=0 value=0", out_query_tag1_ready, out_query_value1);
    end
`endif
    checks++;
    if (out_query_tag2_ready !== 1'b0) begin
      failures++;
      $display("FAIL bypass_other_tag: ready=%0b, required 0", out_query_tag2_ready);
    end
    tick();
    in_cdb_ena = 1'b0;
    #1;
    checks++;
    if (out_query_tag1_ready !== 1'b1 || out_query_value1 !== 32'd7) begin
      failures++;
      $display("FAIL bypass_next_cycle: ready=%0b value=%0d, required ready=1 value=7", out_query_tag1_ready, out_query_value1);
    end
  endtask

  typedef struct {
    logic [3:0]  tag;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        rdy;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  task automatic test_random();
    ent_t q[$];
    ent_t e, h;
    int m_tail, pre_size, pick, r, qi;
    logic [3:0] qt [2];
    logic exp_rdy [2];
    logic [31:0] exp_val [2];
    logic e_reg, e_st, e_rb;
    logic [4:0] e_rd;
    logic [31:0] e_value, e_pc;
    logic [3:0] e_tag;
    logic do_alloc, do_cdb;
    logic [3:0] cdb_tag;
    do_reset();
    m_tail = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle_inputs();
      qt[0] = 4'($urandom_range(0, 15));
      qt[1] = 4'($urandom_range(0, 15));
      in_query_tag1 = qt[0];
      in_query_tag2 = qt[1];
      #1;
      for (int j = 0; j < 2; j++) begin
        exp_rdy[j] = 1'b0;
        exp_val[j] = '0;
        foreach (q[n]) if (q[n].tag == qt[j] && qt[j] != 0 && q[n].rdy) begin
          exp_rdy[j] = 1'b1;
          exp_val[j] = q[n].value;
        end
      end
      checks++;
      if (out_query_tag1_ready !== exp_rdy[0] || out_query_value1 !== exp_val[0] ||
          out_query_tag2_ready !== exp_rdy[1] || out_query_value2 !== exp_val[1]) begin
        failures++;
        $display("FAIL rnd_query: t1=%0d %0b/%h t2=%0d %0b/%h, required %0b/%h %0b/%h",
                 qt[0], out_query_tag1_ready, out_query_value1, qt[1], out_query_tag2_ready, out_query_value2,
                 exp_rdy[0], exp_val[0], exp_rdy[1], exp_val[1]);
      end
      checks++;
      if (out_tobe_tag !== 4'(m_tail) || out_full !== (q.size() == 15)) begin
        failures++;
        $display("FAIL rnd_ptrs: tobe_tag=%0d full=%0b, required %0d %0b", out_tobe_tag, out_full, m_tail, q.size() == 15);
      end

      do_alloc = ($urandom_range(0, 9) < 7);
      if (do_alloc) begin
        r = $urandom_range(0, 19);
        e.op = (r < 12) ? OP_ADD : (r < 15) ? OP_ST : (r < 18) ? OP_BEQ : OP_JALR;
        e.rd = 5'($urandom_range(0, 31));
        e.pc = {$urandom_range(0, 1073741823), 2'b00};
        e.pred = 1'($urandom_range(0, 1));
        drive_alloc(e.op, e.rd, e.pc, e.pred);
      end
      do_cdb = 1'b0;
      pick = -1;
      foreach (q[n]) if (!q[n].rdy && pick < 0 && $urandom_range(0, 2) == 0) pick = n;
      if (pick >= 0 && $urandom_range(0, 9) < 8) begin
        do_cdb = 1'b1;
        cdb_tag = q[pick].tag;
        in_cdb_ena = 1'b1; in_cdb_tag = cdb_tag; in_cdb_value = $urandom;
        in_cdb_target = {$urandom_range(0, 1073741823), 2'b00};
        in_cdb_taken = (q[pick].op == OP_BEQ && $urandom_range(0, 3) != 0) ? q[pick].pred : 1'($urandom_range(0, 1));
      end

      e_reg = 0; e_st = 0; e_rb = 0; e_rd = 0; e_value = 0; e_pc = 0; e_tag = 0;
      pre_size = q.size();
      if (q.size() > 0 && q[0].rdy) begin
        h = q.pop_front();
        e_tag = h.tag;
        if (h.op == OP_ST) e_st = 1'b1;
        else if (h.op == OP_BEQ) begin
          if (h.taken != h.pred) begin
            e_rb = 1'b1;
            e_pc = h.taken ? h.target : h.pc + 32'd4;
          end
        end else if (h.op == OP_JALR) begin
          e_reg = 1'b1; e_rd = h.rd; e_value = h.value; e_rb = 1'b1; e_pc = h.target;
        end else begin
          e_reg = (h.rd != 0); e_rd = h.rd; e_value = h.value;
        end
      end
      if (e_rb) begin
        q.delete();
        m_tail = 1;
      end else begin
        if (do_cdb) begin
          qi = -1;
          foreach (q[n]) if (q[n].tag == cdb_tag) qi = n;
          if (qi >= 0) begin
            q[qi].rdy = 1'b1; q[qi].value = in_cdb_value;
            q[qi].taken = in_cdb_taken; q[qi].target = in_cdb_target;
          end
        end
        if (do_alloc && pre_size < 15) begin
          e.tag = 4'(m_tail); e.rdy = 1'b0; e.value = '0; e.taken = 1'b0; e.target = '0;
          q.push_back(e);
          m_tail = (m_tail == 15) ? 1 : m_tail + 1;
        end
      end

      tick();
      checks++;
      if (out_commit_reg_ena !== e_reg || (e_reg &&
          (out_commit_rd !== e_rd || out_commit_value !== e_value || out_commit_tag !== e_tag))) begin
        failures++;
        $display("FAIL rnd_regwrite: ena=%0b rd=%0d val=%h tag=%0d, required ena=%0b rd=%0d val=%h tag=%0d",
                 out_commit_reg_ena, out_commit_rd, out_commit_value, out_commit_tag, e_reg, e_rd, e_value, e_tag);
      end
      checks++;
      if (out_commit_store_ena !== e_st || (e_st && out_commit_store_tag !== e_tag)) begin
        failures++;
        $display("FAIL rnd_store: ena=%0b tag=%0d, required ena=%0b tag=%0d",
                 out_commit_store_ena, out_commit_store_tag, e_st, e_tag);
      end
      checks++;
      if (out_rollback !== e_rb || (e_rb && out_correct_pc !== e_pc)) begin
        failures++;
        $display("FAIL rnd_rollback: rb=%0b pc=%h, required rb=%0b pc=%h", out_rollback, out_correct_pc, e_rb, e_pc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_fill();
    test_commit_add();
    test_branch_rollback();
    test_wrap();
    test_tag0();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

- Circular reorder buffer for the out-of-order core.
- Sits between decode, the CDB, the regfile and the LSqueue:
  - accepts in-order allocations from decode and hands decode the next tag;
  - answers decode's two same-cycle operand queries;
  - captures CDB results and commits one instruction per cycle in program order;
  - raises rollback on branch/JALR mispredict.

## Interface
- ROB_SIZE, 16 — physical entries. Tag 0 (`ZERO_ROB`) is reserved as "no tag", so 15 are usable.
- TAG_W, 4 — tag width; equals `ROB_WIDTH`.

Ports:
- clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous reset.
- in_assign_ena  in  1  allocate the entry at tail.
- in_inst  in  32  instruction word; opcode bits [6:0].
- in_rd  in  5  destination register.
- in_pc  in  32  instruction PC.
- in_predicted_taken  in  1  fetch prediction.
- out_tobe_tag  out  TAG_W  tag the next allocation receives.
- out_full  out  1  15 entries valid.
- in_query_tag1, in_query_tag2  in  TAG_W  operand tags from decode.
- out_query_tag1_ready, out_query_tag2_ready  out  1  result present (combinational).
- out_query_value1, out_query_value2  out  32  result, 0 when not ready.
- in_cdb_ena  in  1  CDB broadcast valid.
- in_cdb_tag  in  TAG_W  CDB tag.
- in_cdb_value  in  32  CDB value.
- in_cdb_taken  in  1  resolved branch direction.
- in_cdb_target  in  32  resolved branch/JALR target.
- out_commit_reg_ena  out  1  regfile write.
- out_commit_rd  out  5  regfile write register.
- out_commit_value  out  32  regfile write value.
- out_commit_tag  out  TAG_W  regfile clears busy if its tag matches.
- out_commit_store_ena  out  1  store at head may perform.
- out_commit_store_tag  out  TAG_W  that store's tag.
- out_rollback  out  1  flush pulse.
- out_correct_pc  out  32  fetch redirect PC.

## Operation
- Entry fields: valid, ready, inst opcode, rd, pc, predicted_taken, value, taken, target.
- Pointers head and tail (both TAG_W bits) plus a count (0..15).
  - Increment wraps 15→1; tag 0 is never allocated.
- Allocation: when in_assign_ena && !out_full, write at tail; valid=1, ready=0.
  - Then tail advances and count increments.
  - Allocation while full is ignored; decode gates ena.
- out_tobe_tag = tail.
- CDB write: when in_cdb_ena, in_cdb_tag≠0 and the entry is valid, store value/taken/target and set ready=1.
  - A CDB write to tag 0 or to an invalid entry is dropped.
- Query:
  - ready = entry valid && entry ready; value = entry value.
  - Tag 0 always returns ready=0, value=0.
- Commit happens when the head entry is valid and ready. Exactly one of the following, then head advances and count decrements:
  - STORE: out_commit_store_ena=1 and out_commit_store_tag=head. No regfile write.
  - BRANCH: no write. If taken≠predicted_taken, rollback with correct_pc = taken ? target : pc+4.
  - JALR: regfile write of rd and value, plus unconditional rollback with correct_pc=target.
  - Others: out_commit_reg_ena=1 when rd≠0, with rd/value/tag=head.
- Rollback: on the same edge, all entries are invalidated, head=tail=1, count=0.
  - out_rollback=1 and out_correct_pc are registered and held for one cycle.
- Simultaneous events:
  - Allocate + commit in the same cycle: count unchanged.
  - Allocate + rollback: the allocation is dropped.
  - CDB + rollback: the CDB write is dropped.

## Timing
- Reset: every registered output is 0. head=tail=1, count=0, all entries invalid, out_tobe_tag=1, out_full=0.
- Allocation at edge t: entry and new out_tobe_tag are visible after t.
- CDB at edge t: ready is visible after t; the commit pulse is registered at edge t+1.
- Commit and rollback outputs are single-cycle registered pulses, deasserted by default every cycle.
- Throughput is one commit per cycle; back-to-back ready entries commit on consecutive cycles.
- rst asserted mid-operation overrides everything at that edge.

## Configuration
- ROB_CDB_BYPASS_EN:
  - Defined: a query whose tag equals in_cdb_tag while in_cdb_ena (tag≠0, entry valid) returns ready=1 with in_cdb_value in the same cycle.
  - Undefined: queries see only stored state, one cycle later.

## Test plan
- Reset, then 15 allocations:
  - out_tobe_tag steps 1..15;
  - out_full=1 after the 15th;
  - a 16th ena leaves tail at 1 and count at 15.
- Allocate tag 1 (ADD rd=5), CDB tag1 value 0x1234:
  - next cycle, query tag1 ready=1, value 0x1234;
  - the following edge commits with rd=5, value 0x1234, tag=1.
- BEQ at pc 0x100, predicted 0, CDB taken=1 target 0x200, younger entries allocated:
  - rollback pulse with correct_pc 0x200;
  - out_tobe_tag=1 and out_full=0 afterwards.
- Wrap test:
  - allocate/commit 20 ADDs streaming;
  - tags wrap 15→1, never 0;
  - commits stay in order.
- Query tag 0 while a CDB broadcasts on tag 0: ready=0, value=0, no entry modified.
- Bypass: with ROB_CDB_BYPASS_EN, CDB tag3 value 7 and query tag3 in the same cycle give ready=1, value 7. Without the macro, ready=0 that cycle.
